// File: rtl/seg7_scan_driver.sv
// Seven-segment scan driver for the processor debug word: captures a 32-bit value,
// shows one 16-bit half as four multiplexed hex digits, and a debounced button selects the half.
module seg7_scan_driver #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        half_btn,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        half_sel
);

  localparam int PS_W = $clog2(REFRESH_DIV);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(REFRESH_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0]     data_q;
  logic [PS_W-1:0] prescaler;
  logic [1:0]      digit_idx;
  logic            tick;
  logic [1:0]      sync_q;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            db_level_q;
  logic [15:0]     half_word;
  logic [3:0]      nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data_in;
    end
  end

  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (tick) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  // Two-flop synchronizer followed by a counter that only accepts a level held for the full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], half_btn};
      db_level_q <= db_level;
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_q[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_sel <= 1'b0;
    end else if (db_level && !db_level_q) begin
      half_sel <= ~half_sel;
    end
  end

  // NOTE: every signal driven in always_comb gets a value on every path so no latch is inferred.
  always_comb begin
    half_word = half_sel ? data_q[31:16] : data_q[15:0];
    nibble    = half_word[{digit_idx, 2'b00} +: 4];
  end

  // The cycle after tick is a dark gap so the previous digit's segments never ghost onto the next anode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= (tick || blank) ? 4'b1111 : ~(4'b0001 << digit_idx);
      seg <= hex_to_seg(nibble);
      dp  <= (half_sel && (digit_idx == 2'd3) && !blank && !tick) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with REFRESH_DIV=4, DEBOUNCE_CYCLES=3.
module tb_seg7_scan_driver;

  localparam int REFRESH_DIV     = 4;
  localparam int DEBOUNCE_CYCLES = 3;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [31:0] data_in  = '0;
  logic        load     = 1'b0;
  logic        half_btn = 1'b0;
  logic        blank    = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        half_sel;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_driver #(
    .REFRESH_DIV    (REFRESH_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .half_btn(half_btn),
    .blank   (blank),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .half_sel(half_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full 16-cycle scan: three lit cycles per digit, then one dark gap cycle.
  task automatic check_scan(input string tag, input logic [27:0] segs, input logic upper);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    for (int s = 0; s < 4; s++) begin
      exp_an  = ~(4'b0001 << s);
      exp_seg = segs[7*s +: 7];
      exp_dp  = (upper && s == 3) ? 1'b0 : 1'b1;
      for (int c = 0; c < REFRESH_DIV - 1; c++) begin
        step(1);
        check($sformatf("%s an d%0d", tag, s), 32'(an), 32'(exp_an));
        check($sformatf("%s seg d%0d", tag, s), 32'(seg), 32'(exp_seg));
        check($sformatf("%s dp d%0d", tag, s), 32'(dp), 32'(exp_dp));
      end
      step(1);
      check($sformatf("%s gap an d%0d", tag, s), 32'(an), 32'hF);
      check($sformatf("%s gap dp d%0d", tag, s), 32'(dp), 32'h1);
    end
  endtask

  initial begin
    logic [6:0] bounce;
    bounce = 7'b0110101;

    step(3);
    check("rst an", 32'(an), 32'hF);
    check("rst seg", 32'(seg), 32'h7F);
    check("rst dp", 32'(dp), 32'h1);
    check("rst half_sel", 32'(half_sel), 32'h0);
    reset = 1'b1;

    step(1);
    check("boot an e1", 32'(an), 32'hE);
    check("boot seg e1", 32'(seg), 32'h40);
    step(1);
    check("boot an e2", 32'(an), 32'hE);
    step(1);
    check("boot an e3", 32'(an), 32'hE);
    step(1);
    check("boot first tick gap", 32'(an), 32'hF);
    step(1);
    check("boot an e5", 32'(an), 32'hD);
    step(10);

    // load lands on the tick edge, so the next digit already shows the new word
    load    = 1'b1;
    data_in = 32'h1234_ABCD;
    step(1);
    check("load on tick gap", 32'(an), 32'hF);
    load = 1'b0;
    check_scan("lower", {7'h08, 7'h03, 7'h46, 7'h21}, 1'b0);

    half_btn = 1'b1;
    step(5);
    check("btn before toggle", 32'(half_sel), 32'h0);
    step(1);
    check("btn toggle", 32'(half_sel), 32'h1);
    step(4);
    half_btn = 1'b0;
    step(6);
    check_scan("upper", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1);
    check("held btn single toggle", 32'(half_sel), 32'h1);

    for (int i = 0; i < 7; i++) begin
      half_btn = bounce[i];
      step(1);
    end
    half_btn = 1'b0;
    step(6);
    check("bounce rejected", 32'(half_sel), 32'h1);

    blank = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("blank an c%0d", i), 32'(an), 32'hF);
      check($sformatf("blank dp c%0d", i), 32'(dp), 32'h1);
    end
    blank = 1'b0;
    step(1);
    check("unblank an c0", 32'(an), 32'hD);
    step(1);
    check("unblank an c1", 32'(an), 32'hD);
    step(1);
    check("unblank gap", 32'(an), 32'hF);
    step(1);
    check("unblank next digit", 32'(an), 32'hB);

    half_btn = 1'b1;
    step(5);
    check("btn2 before toggle", 32'(half_sel), 32'h1);
    half_btn = 1'b0;
    step(1);
    check("btn2 toggle back", 32'(half_sel), 32'h0);

    load    = 1'b1;
    data_in = 32'h0;
    step(2);
    check("live an", 32'(an), 32'hE);
    check("live seg zero", 32'(seg), 32'h40);
    data_in = 32'h0000_FFFF;
    step(1);
    check("live seg latency", 32'(seg), 32'h40);
    step(1);
    check("live seg F", 32'(seg), 32'h0E);
    check("live an held", 32'(an), 32'hE);

    #2;
    reset = 1'b0;
    #1;
    check("async rst an", 32'(an), 32'hF);
    check("async rst seg", 32'(seg), 32'h7F);
    check("async rst dp", 32'(dp), 32'h1);
    check("async rst half_sel", 32'(half_sel), 32'h0);
    load    = 1'b0;
    data_in = 32'h0;
    step(2);
    reset = 1'b1;
    step(1);
    check("restart an e1", 32'(an), 32'hE);
    step(1);
    check("restart data cleared", 32'(seg), 32'h40);
    step(1);
    check("restart an e3", 32'(an), 32'hE);
    step(1);
    check("restart first tick gap", 32'(an), 32'hF);
    step(1);
    check("restart an e5", 32'(an), 32'hD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Display back-end for the single-cycle processor's debug path. It captures the 32-bit debug word chosen by the data selector (PC, register read data, write-back data or ALU result) and shows one 16-bit half as four hex digits. The four digits are time-multiplexed on a common-anode seven-segment display. A debounced push-button toggles between the lower and upper half. It drives the board-level `seg`/`an`/`dp` pins directly.

## Interface

Parameters:
- `REFRESH_DIV`, default 50000: clk cycles per digit slot. Legal range is ≥ 2.
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable synchronized samples required to accept a button level. Legal range is ≥ 1.

Ports:
- `clk` — input, 1 bit. Single clock. All state is on the rising edge.
- `reset` — input, 1 bit. Asynchronous, active-low.
- `data_in` — input, 32 bits. Debug word from the data selector.
- `load` — input, 1 bit. Capture strobe: `data_in` is sampled on every edge where it is high.
- `half_btn` — input, 1 bit. Raw, asynchronous, bouncing push-button. Active-high.
- `blank` — input, 1 bit. Forces all anodes off while high.
- `seg` — output, 7 bits. Active-low segments, ordered {g,f,e,d,c,b,a}.
- `an` — output, 4 bits. Active-low anodes. `an[0]` is the rightmost digit.
- `dp` — output, 1 bit. Active-low decimal point.
- `half_sel` — output, 1 bit. 0 selects `data_q[15:0]`; 1 selects `data_q[31:16]`.

## Operation

**Reset** (asynchronous, when `reset`=0): `data_q`=0, `half_sel`=0, digit index=0, prescaler=0, sync/debounce state=0, `an`=4'b1111, `seg`=7'h7F, `dp`=1.

**Capture**
- `data_q <= data_in` on every edge with `load`=1.
- With `load` tied high, the block tracks the live value.

**Prescaler**
- Counts 0..`REFRESH_DIV`-1, then wraps to 0.
- `tick` = (prescaler == `REFRESH_DIV`-1).
- On `tick`, the digit index advances 0→1→2→3→0.

**Nibble select**
- Nibble for index i = `half_sel` ? `data_q[16+4i +: 4]` : `data_q[4i +: 4]`.

**Hex decode** (active-low, {g..a}):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

**Outputs** (all registered):
- `an` <= (`tick` | `blank`) ? 4'b1111 : ~(4'b0001 << index).
- `seg` <= decode(nibble).
- `dp` <= (`half_sel` & index==3 & ~`blank` & ~`tick`) ? 0 : 1. The dp on digit 3 marks the upper half.

**Button**
- Two-flop synchronizer, then a stability counter.
- The debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples differ from it. Any sample equal to the current level clears the counter.
- A 0→1 transition of the debounced level toggles `half_sel`. Release does nothing.

## Timing

**Output latency**
- `load` at edge N: `data_q` is updated at N.
- `seg` reflects the new value for the current digit at edge N+1. This is 1 cycle of output latency, with no wait for the next slot.

**Digit slot**
- Each slot is exactly `REFRESH_DIV` cycles: 1 cycle with `an`=1111 (anti-ghosting gap, on the cycle after `tick`), then `REFRESH_DIV`-1 cycles with the digit driven.
- A full scan is 4×`REFRESH_DIV` cycles.

**Button**
- Latency from a clean `half_btn` rise to the `half_sel` toggle is `DEBOUNCE_CYCLES`+3 cycles: 2 sync, `DEBOUNCE_CYCLES` count, 1 toggle.
- The displayed half changes on the following edge.

**Blank**
- `blank` takes effect on `an` and `dp` 1 cycle later.
- The prescaler, index, capture and button logic keep running while blanked. Scan phase is preserved on release.

**Boundary cases**
- `load` during `tick`: both take effect. The new index shows the new data.
- A `half_sel` toggle coinciding with `tick`: the new digit uses the new half.
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously). After release, scanning restarts at index 0 with a full slot before the first `tick`.
- A button pulse shorter than `DEBOUNCE_CYCLES`: no toggle.
- A button held indefinitely: exactly one toggle.

## Test plan

All scenarios use `REFRESH_DIV`=4 and `DEBOUNCE_CYCLES`=3.

1. **Reset values.** Assert `reset`=0 mid-scan → `an`=1111, `seg`=7F, `dp`=1 and `half_sel`=0, without waiting for a clock edge. After release, the first `tick` occurs 4 cycles later.
2. **Lower-half scan.** Pulse `load` with `data_in`=0x1234ABCD → over one 16-cycle scan, expect:
   - `an`=1110/`seg`=21 (d)
   - `an`=1101/`seg`=46 (C)
   - `an`=1011/`seg`=03 (b)
   - `an`=0111/`seg`=08 (A)
   - Each digit is held 3 cycles and separated by 1 cycle of `an`=1111.
3. **Toggle to upper half.** Hold `half_btn`=1 for 10 cycles → `half_sel`=1 after 6 cycles. The scan then shows 4, 3, 2, 1 (19, 30, 24, 79), with `dp`=0 only while `an`=0111. Exactly one toggle occurs.
4. **Bounce rejection.** Drive `half_btn` as a 1,0,1,0,1,1,0 pattern (no run of ≥3 ones after synchronization) → `half_sel` is unchanged.
5. **Blank and live load.** Set `blank`=1 for 8 cycles → `an`=1111 throughout, and the scan resumes at the correct phase afterwards. Hold `load`=1 while `data_in` changes 0→0xFFFF on a lit digit → `seg` becomes 0E one cycle later.
